// File: rtl/proc_datapath.sv
// rtl/proc_datapath.sv - processor datapath: PC, IR, register file, data memory, ALU
// Responds to control-unit strobes and returns the fetched instruction word.
module proc_datapath #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_clr,
  input  logic            pc_up,
  input  logic            ir_ld,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic [7:0]      d_addr,
  input  logic            d_wr,
  input  logic            rf_s,
  input  logic [3:0]      rf_w_addr,
  input  logic            rf_w_wr,
  input  logic [3:0]      rf_ra_addr,
  input  logic [3:0]      rf_rb_addr,
  input  logic [2:0]      alu_s,
  input  logic            ext_wr,
  input  logic [7:0]      ext_addr,
  input  logic [15:0]     ext_wdata,
  output logic [15:0]     ir,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     ra_data,
  output logic [15:0]     rb_data,
  output logic [15:0]     alu_result,
  output logic            alu_zero,
  output logic [15:0]     dmem_rdata
);

  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic [15:0]     r_rf   [16];
  logic [15:0]     r_dmem [256];
  logic [15:0]     w_alu;
  logic [15:0]     w_rf_wdata;

  // IR samples imem_data at the pre-edge pc, so fetch can advance pc in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
      r_ir <= '0;
    end else begin
      if (pc_clr)
        r_pc <= '0;
      else if (pc_up)
        r_pc <= r_pc + PC_W'(1);
      if (ir_ld)
        r_ir <= imem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++)
        r_rf[i] <= '0;
    end else if (rf_w_wr) begin
      r_rf[rf_w_addr] <= w_rf_wdata;
    end
  end

  // Memory contents survive reset; a datapath store takes precedence over a preload
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (d_wr)
        r_dmem[d_addr] <= ra_data;
      else if (ext_wr)
        r_dmem[ext_addr] <= ext_wdata;
    end
  end

  always_comb begin
    w_alu = '0;
    case (alu_s)
      3'd0:    w_alu = ra_data;
      3'd1:    w_alu = ra_data + rb_data;
      3'd2:    w_alu = ra_data - rb_data;
      3'd3:    w_alu = ra_data & rb_data;
      3'd4:    w_alu = ra_data | rb_data;
      3'd5:    w_alu = ra_data ^ rb_data;
      3'd6:    w_alu = ~ra_data;
      default: w_alu = '0;
    endcase
  end

  assign ra_data    = r_rf[rf_ra_addr];
  assign rb_data    = r_rf[rf_rb_addr];
  assign dmem_rdata = r_dmem[d_addr];
  assign w_rf_wdata = rf_s ? dmem_rdata : w_alu;
  assign alu_result = w_alu;
  assign alu_zero   = (w_alu == 16'h0000);
  assign pc         = r_pc;
  assign imem_addr  = r_pc;
  assign ir         = r_ir;

endmodule

// File: tb/tb_proc_datapath.sv
// tb/tb_proc_datapath.sv - self-checking bench for proc_datapath
// Table vectors, directed corner sequences and randomized cycles against a reference model.
module tb_proc_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_clr, pc_up, ir_ld;
  logic [6:0]  imem_addr;
  logic [15:0] imem_data;
  logic [7:0]  d_addr;
  logic        d_wr, rf_s;
  logic [3:0]  rf_w_addr;
  logic        rf_w_wr;
  logic [3:0]  rf_ra_addr, rf_rb_addr;
  logic [2:0]  alu_s;
  logic        ext_wr;
  logic [7:0]  ext_addr;
  logic [15:0] ext_wdata;
  logic [15:0] ir;
  logic [6:0]  pc;
  logic [15:0] ra_data, rb_data, alu_result, dmem_rdata;
  logic        alu_zero;

  logic [15:0] imem_rom [128];
  assign imem_data = imem_rom[imem_addr];

  always #5 clk = ~clk;

  proc_datapath #(.PC_W(7)) dut (
    .clk(clk), .reset(reset), .pc_clr(pc_clr), .pc_up(pc_up), .ir_ld(ir_ld),
    .imem_addr(imem_addr), .imem_data(imem_data), .d_addr(d_addr), .d_wr(d_wr),
    .rf_s(rf_s), .rf_w_addr(rf_w_addr), .rf_w_wr(rf_w_wr), .rf_ra_addr(rf_ra_addr),
    .rf_rb_addr(rf_rb_addr), .alu_s(alu_s), .ext_wr(ext_wr), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ir(ir), .pc(pc), .ra_data(ra_data), .rb_data(rb_data),
    .alu_result(alu_result), .alu_zero(alu_zero), .dmem_rdata(dmem_rdata)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_rf   [16];
  logic [15:0] m_dmem [256];
  bit          m_dk   [256];

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        zero;
  } alu_vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    int ia = int'(a);
    int ib = int'(b);
    case (op)
      3'd0:    return a;
      3'd1:    return 16'((ia + ib) % 65536);
      3'd2:    return 16'((ia - ib + 65536) % 65536);
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return 16'(65535 - ia);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic clear_strobes();
    pc_clr = 0; pc_up = 0; ir_ld = 0; d_wr = 0; rf_s = 0; rf_w_wr = 0; ext_wr = 0;
    alu_s = 0; rf_w_addr = 0; rf_ra_addr = 0; rf_rb_addr = 0;
    d_addr = 0; ext_addr = 0; ext_wdata = 0;
  endtask

  task automatic check_comb();
    logic [15:0] a, b, r;
    a = m_rf[rf_ra_addr];
    b = m_rf[rf_rb_addr];
    r = alu_ref(alu_s, a, b);
    chk("pc", {9'd0, pc}, 16'(m_pc));
    chk("ir", ir, m_ir);
    chk("ra_data", ra_data, a);
    chk("rb_data", rb_data, b);
    chk("alu_result", alu_result, r);
    chk("alu_zero", {15'd0, alu_zero}, {15'd0, r == 16'h0000});
    if (m_dk[d_addr]) chk("dmem_rdata", dmem_rdata, m_dmem[d_addr]);
  endtask

  task automatic model_update();
    logic [15:0] wd, sd;
    if (reset) begin
      m_pc = 0;
      m_ir = 0;
      for (int i = 0; i < 16; i++) m_rf[i] = 0;
    end else begin
      sd = m_rf[rf_ra_addr];
      wd = rf_s ? m_dmem[d_addr] : alu_ref(alu_s, m_rf[rf_ra_addr], m_rf[rf_rb_addr]);
      if (ir_ld) m_ir = imem_rom[m_pc];
      if (pc_clr) m_pc = 0;
      else if (pc_up) m_pc = (m_pc + 1) % 128;
      if (rf_w_wr) m_rf[rf_w_addr] = wd;
      if (d_wr) begin
        m_dmem[d_addr] = sd;
        m_dk[d_addr] = 1;
      end else if (ext_wr) begin
        m_dmem[ext_addr] = ext_wdata;
        m_dk[ext_addr] = 1;
      end
    end
  endtask

  // Inputs are driven just after a rising edge; this checks, advances the model, and clocks.
  task automatic cyc();
    #1;
    check_comb();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic load_reg(input logic [3:0] idx, input logic [15:0] val);
    clear_strobes();
    ext_wr = 1; ext_addr = 8'hFE; ext_wdata = val;
    cyc();
    clear_strobes();
    d_addr = 8'hFE; rf_s = 1; rf_w_addr = idx; rf_w_wr = 1;
    cyc();
    clear_strobes();
  endtask

  task automatic sweep_zero(input string name);
    for (int i = 0; i < 16; i++) begin
      rf_ra_addr = 4'(i);
      rf_rb_addr = 4'(15 - i);
      #1;
      chk({name, "_ra"}, ra_data, 16'h0000);
      chk({name, "_rb"}, rb_data, 16'h0000);
    end
  endtask

  alu_vec_t    vecs [12];
  logic [15:0] saved;

  initial begin
    vecs[0]  = '{3'd1, 16'h0005, 16'h0003, 16'h0008, 1'b0};
    vecs[1]  = '{3'd2, 16'h0005, 16'h0003, 16'h0002, 1'b0};
    vecs[2]  = '{3'd2, 16'h0000, 16'h0001, 16'hFFFF, 1'b0};
    vecs[3]  = '{3'd7, 16'h0000, 16'h0001, 16'h0000, 1'b1};
    vecs[4]  = '{3'd0, 16'hABCD, 16'h1234, 16'hABCD, 1'b0};
    vecs[5]  = '{3'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[6]  = '{3'd3, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
    vecs[7]  = '{3'd4, 16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0};
    vecs[8]  = '{3'd5, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1};
    vecs[9]  = '{3'd6, 16'h0F0F, 16'h0000, 16'hF0F0, 1'b0};
    vecs[10] = '{3'd6, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
    vecs[11] = '{3'd2, 16'h8000, 16'h0001, 16'h7FFF, 1'b0};

    for (int i = 0; i < 128; i++) imem_rom[i] = 16'($urandom);
    imem_rom[0] = 16'h1F29;
    imem_rom[2] = 16'hC0DE;

    clear_strobes();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    m_pc = 0;
    m_ir = 0;
    for (int i = 0; i < 16; i++) m_rf[i] = 0;

    // Reset state
    #1;
    chk("reset_pc", {9'd0, pc}, 16'h0000);
    chk("reset_imem_addr", {9'd0, imem_addr}, 16'h0000);
    chk("reset_ir", ir, 16'h0000);
    sweep_zero("reset_rf");
    rf_ra_addr = 0; rf_rb_addr = 0;
    for (int op = 0; op < 8; op++) begin
      alu_s = 3'(op);
      #1;
      chk("reset_alu_result", alu_result, (op == 6) ? 16'hFFFF : 16'h0000);
      chk("reset_alu_zero", {15'd0, alu_zero}, (op == 6) ? 16'h0000 : 16'h0001);
    end
    clear_strobes();

    for (int i = 0; i < 256; i++) begin
      ext_wr = 1; ext_addr = 8'(i); ext_wdata = 16'($urandom);
      cyc();
    end
    clear_strobes();

    // Fetch
    ir_ld = 1; pc_up = 1;
    cyc();
    clear_strobes();
    #1;
    chk("fetch_ir", ir, 16'h1F29);
    chk("fetch_pc", {9'd0, pc}, 16'h0001);

    // Load: same-cycle read sees old value
    ext_wr = 1; ext_addr = 8'h0A; ext_wdata = 16'h1234;
    cyc();
    clear_strobes();
    d_addr = 8'h0A; rf_s = 1; rf_w_addr = 7; rf_w_wr = 1; rf_ra_addr = 7;
    #1;
    chk("load_same_cycle", ra_data, 16'h0000);
    cyc();
    clear_strobes();
    rf_ra_addr = 7;
    #1;
    chk("load_next_cycle", ra_data, 16'h1234);

    // ALU through register writes
    load_reg(1, 16'h0005);
    load_reg(2, 16'h0003);
    rf_ra_addr = 1; rf_rb_addr = 2; alu_s = 1; rf_w_addr = 3; rf_w_wr = 1;
    cyc();
    alu_s = 2; rf_w_addr = 4;
    cyc();
    clear_strobes();
    rf_ra_addr = 3; rf_rb_addr = 4;
    #1;
    chk("alu_add_r3", ra_data, 16'h0008);
    chk("alu_sub_r4", rb_data, 16'h0002);

    for (int i = 0; i < 12; i++) begin
      load_reg(1, vecs[i].a);
      load_reg(2, vecs[i].b);
      rf_ra_addr = 1; rf_rb_addr = 2; alu_s = vecs[i].op;
      #1;
      chk($sformatf("vec%0d_result", i), alu_result, vecs[i].res);
      chk($sformatf("vec%0d_zero", i), {15'd0, alu_zero}, {15'd0, vecs[i].zero});
      clear_strobes();
    end

    // Store with colliding preload
    load_reg(15, 16'hBEEF);
    ext_wr = 1; ext_addr = 8'h29; ext_wdata = 16'h5A5A;
    cyc();
    clear_strobes();
    rf_ra_addr = 15; d_addr = 8'h29; d_wr = 1;
    ext_wr = 1; ext_addr = 8'h29; ext_wdata = 16'h1111;
    #1;
    chk("store_same_cycle", dmem_rdata, 16'h5A5A);
    cyc();
    clear_strobes();
    d_addr = 8'h29;
    #1;
    chk("store_next_cycle", dmem_rdata, 16'hBEEF);

    // Simultaneous load and store at one address: load sees pre-store data
    load_reg(3, 16'h0008);
    rf_s = 1; rf_w_addr = 9; rf_w_wr = 1; d_addr = 8'h29; d_wr = 1; rf_ra_addr = 3;
    cyc();
    clear_strobes();
    rf_ra_addr = 9; d_addr = 8'h29;
    #1;
    chk("ldst_rf", ra_data, 16'hBEEF);
    chk("ldst_dmem", dmem_rdata, 16'h0008);

    // PC boundaries
    pc_clr = 1;
    cyc();
    clear_strobes();
    pc_up = 1;
    repeat (127) cyc();
    clear_strobes();
    #1;
    chk("pc_127", {9'd0, pc}, 16'd127);
    pc_up = 1;
    cyc();
    clear_strobes();
    #1;
    chk("pc_wrap", {9'd0, pc}, 16'd0);
    pc_up = 1;
    repeat (5) cyc();
    clear_strobes();
    #1;
    chk("pc_5", {9'd0, pc}, 16'd5);
    pc_clr = 1; pc_up = 1;
    cyc();
    clear_strobes();
    #1;
    chk("pc_clr_priority", {9'd0, pc}, 16'd0);

    // Randomized cycles
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 39) == 0);
      pc_clr     = ($urandom_range(0, 7) == 0);
      pc_up      = 1'($urandom);
      ir_ld      = 1'($urandom);
      d_addr     = 8'($urandom);
      d_wr       = ($urandom_range(0, 3) == 0);
      rf_s       = 1'($urandom);
      rf_w_addr  = 4'($urandom);
      rf_w_wr    = 1'($urandom);
      rf_ra_addr = 4'($urandom);
      rf_rb_addr = 4'($urandom);
      alu_s      = 3'($urandom);
      ext_wr     = ($urandom_range(0, 3) == 0);
      ext_addr   = ($urandom_range(0, 1) == 0) ? d_addr : 8'($urandom);
      ext_wdata  = 16'($urandom);
      cyc();
    end
    reset = 0;
    clear_strobes();

    // Reset dominates fetch and memory writes
    pc_clr = 1;
    cyc();
    clear_strobes();
    pc_up = 1;
    repeat (2) cyc();
    clear_strobes();
    load_reg(5, 16'h7777);
    saved = m_dmem[8'h29];
    reset = 1; ir_ld = 1; pc_up = 1; rf_w_wr = 1; rf_w_addr = 6;
    d_wr = 1; d_addr = 8'h29; rf_ra_addr = 5;
    ext_wr = 1; ext_addr = 8'h29; ext_wdata = 16'h4242;
    cyc();
    reset = 0;
    clear_strobes();
    d_addr = 8'h29;
    #1;
    chk("rst_ir", ir, 16'h0000);
    chk("rst_pc", {9'd0, pc}, 16'h0000);
    chk("rst_dmem_kept", dmem_rdata, saved);
    sweep_zero("rst_rf");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/proc_datapath.md
# proc_datapath

Datapath for the team's 16-bit single-cycle-per-state processor: program counter, instruction register, 16x16 register file, 8-bit-addressed 256x16 data memory and 3-bit ALU. It is the responding end of the control-unit interface. It takes the controller's strobes (clear/increment PC, load IR, read/write register file and data memory, ALU select) and returns the instruction word the controller decodes. The bench-side preload port fills data memory before a program runs.

## Interface
- PC_W, 7, program counter width (instruction memory depth 2^PC_W)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- pc_clr  in  1  clear PC to 0
- pc_up  in  1  increment PC
- ir_ld  in  1  load IR from imem_data
- imem_addr  out  PC_W  instruction fetch address (= pc)
- imem_data  in  16  instruction word at imem_addr (combinational)
- d_addr  in  8  data memory address
- d_wr  in  1  write Ra data to dmem[d_addr]
- rf_s  in  1  RF write source: 1 = dmem[d_addr], 0 = ALU result
- rf_w_addr  in  4  RF write address
- rf_w_wr  in  1  RF write enable
- rf_ra_addr, rf_rb_addr  in  4 each  RF read addresses
- alu_s  in  3  ALU operation select
- ext_wr  in  1  bench preload write to data memory
- ext_addr  in  8  preload address
- ext_wdata  in  16  preload data
- ir  out  16  instruction register
- pc  out  PC_W  program counter
- ra_data, rb_data  out  16 each  RF read ports
- alu_result  out  16  ALU output
- alu_zero  out  1  alu_result == 0
- dmem_rdata  out  16  dmem[d_addr]

## Operation
- PC: pc_clr has priority over pc_up. pc_up increments modulo 2^PC_W, so 127 wraps to 0. pc holds when neither strobe is active. imem_addr = pc.
- IR: on ir_ld, ir <= imem_data at the current pc. When ir_ld and pc_up are high in the same cycle, IR captures the word at the old pc and pc advances.
- Register file: 16 x 16 bits.
  - Two combinational read ports.
  - Synchronous write when rf_w_wr is high: data = rf_s ? dmem_rdata : alu_result.
  - No write-to-read bypass. A same-cycle read of the address being written returns the old value.
  - R0 is an ordinary writable register.
- Data memory: 256 x 16 bits, not reset.
  - Combinational read at d_addr.
  - Synchronous write of ra_data to dmem[d_addr] when d_wr is high.
  - ext_wr writes ext_wdata to dmem[ext_addr]. If d_wr is also high that cycle, d_wr wins and the ext write is dropped.
- ALU: combinational, 16-bit, carries and borrows discarded (modulo 2^16).
  - alu_s operations: 0 = A, 1 = A+B, 2 = A−B, 3 = A&B, 4 = A|B, 5 = A^B, 6 = ~A, 7 = 0.
  - A = ra_data, B = rb_data.
- Controller state mapping:
  - Init: pc_clr.
  - Fetch: pc_up + ir_ld.
  - Load: rf_s=1, rf_w_wr.
  - Store: d_wr, Ra = source register.
  - Add: alu_s=1. Sub: alu_s=2.
  - No datapath state is changed in any other cycle.

## Timing
- Reset (synchronous), next edge: pc=0, ir=0, all 16 registers = 0. Data memory contents are unchanged.
- Reset dominates every strobe asserted in the same cycle, including d_wr and ext_wr.
- Reset values of the outputs:
  - pc=0, ir=0, imem_addr=0, ra_data=rb_data=0.
  - alu_result = f(0,0) per alu_s; alu_zero=1 except when alu_s=6.
  - dmem_rdata follows memory contents.
- Latency:
  - Strobe at edge N → pc/ir/RF/dmem updated and visible on outputs after edge N.
  - Read ports, ALU and dmem_rdata are combinational from the address/select inputs, zero cycles.
- Load with rf_s=1 writes the dmem_rdata present in the same cycle, i.e. pre-write contents if d_wr targets the same address.
- A simultaneous store (d_wr) and RF write in one cycle is legal. Both complete at the same edge from pre-edge values.

## Test plan
- Reset: run arbitrary strobes, then assert reset 1 cycle. Required: pc=0, ir=0, rf_ra_addr swept 0..15 reads 0.
- Fetch: pc=0, imem_data=16'h1F29, ir_ld=pc_up=1 for one cycle. Required: ir=16'h1F29, pc=1.
- Load:
  - ext_wr dmem[8'h0A]=16'h1234.
  - d_addr=8'h0A, rf_s=1, rf_w_addr=7, rf_w_wr=1 for one cycle.
  - Same cycle, Ra=7 reads 0. Next cycle, Ra=7 reads 16'h1234.
- ALU:
  - r1=5, r2=3; alu_s=1, rf_s=0, W=3 → r3=8. Then alu_s=2, W=4 → r4=2.
  - With r1=0, r2=1, alu_s=2 → alu_result=16'hFFFF.
  - Same operands, alu_s=7 → alu_zero=1.
- Store:
  - r15=16'hBEEF; Ra=15, d_addr=8'h29, d_wr=1.
  - Same cycle, dmem_rdata shows the old value. Next cycle, dmem_rdata=16'hBEEF.
  - A colliding ext_wr to 8'h29 in the store cycle is dropped.
- PC boundaries:
  - pc=127 with pc_up → 0.
  - pc=5 with pc_clr=pc_up=1 → 0.
  - Reset together with ir_ld → ir=0.
